hdmi_fetch_scheduler: RTL and testbench
=======================================

Name: hdmi_fetch_scheduler

Overview:
Sequences DDR burst reads that keep the HDMI pixel FIFO fed for one video frame. It walks the frame line by line from a software-programmed base address and stride. Each line is split into fixed-size bursts, and a burst is issued only when the FIFO has room for the whole burst. It drives the user-logic master read command interface and sits between the slave config registers, the pixel FIFO and the bus master.

Parameters:
FIFO_DEPTH, 256, pixel FIFO capacity in 32-bit words
BURST_WORDS, 16, maximum words per burst read (power of two, at most FIFO_DEPTH)
LEVEL_W, 9, width of fifo_level; must hold 0..FIFO_DEPTH

Ports:
Bus2IP_Clk  in  1  system clock
Bus2IP_Resetn  in  1  reset, asynchronous, active-low
start  in  1  single-cycle pulse: begin fetching a frame
abort  in  1  single-cycle pulse: stop after any in-flight burst
frame_base_addr  in  32  byte address of pixel (0,0)
line_stride  in  32  byte distance between line starts
hres  in  11  pixels (words) per line
vres  in  10  lines per frame
fifo_level  in  LEVEL_W  current FIFO occupancy in words
mst_rd_req  out  1  burst read request
mst_rd_addr  out  32  burst byte address
mst_rd_len  out  12  burst length in bytes
mst_cmdack  in  1  master accepted the command
mst_cmplt  in  1  burst data fully written to the FIFO
mst_error  in  1  burst error, valid with mst_cmplt
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse when the last burst of a frame completes
line_idx  out  10  index of the line currently being fetched
err_sticky  out  1  set by mst_error; cleared only by reset or start

Behaviour:
- Reset (async assert, sync release): state IDLE; mst_rd_req=0, mst_rd_addr=0, mst_rd_len=0, busy=0, frame_done=0, line_idx=0, err_sticky=0.
- Pixels are 4 bytes, one per FIFO word. Byte address = line_base + 4*words_issued. mst_rd_len = 4*this_len.
- this_len = min(BURST_WORDS, hres - words_issued).
- Address arithmetic is 32-bit and wraps modulo 2^32 without a flag.
- On start in IDLE: latch frame_base_addr, line_stride, hres and vres; clear err_sticky, line_idx and words_issued; set line_base = frame_base_addr; go to WAIT_SPACE.
- start is ignored outside IDLE.
- If the latched hres==0 or vres==0, go to DONE with no requests issued.
- WAIT_SPACE: when FIFO_DEPTH - fifo_level >= this_len, load mst_rd_addr and mst_rd_len, assert mst_rd_req and go to REQ on the next cycle.
- REQ: hold mst_rd_req, mst_rd_addr and mst_rd_len stable until mst_cmdack is sampled high. Deassert mst_rd_req the cycle after the ack, then go to XFER.
- XFER: wait for mst_cmplt; at most one burst is outstanding. On mst_cmplt: if mst_error, set err_sticky and still advance; add this_len to words_issued.
  - If words_issued == hres, go to LINE_END.
  - Otherwise go to WAIT_SPACE.
- LINE_END (1 cycle): clear words_issued.
  - If line_idx == vres-1, go to DONE.
  - Otherwise increment line_idx, add line_stride to line_base and go to WAIT_SPACE.
- DONE (1 cycle): frame_done=1, then go to IDLE.
- abort in IDLE or WAIT_SPACE: go to IDLE next cycle; no frame_done.
- abort in REQ or XFER: record a pending abort. The handshake completes normally (the request is never withdrawn before ack). On mst_cmplt, go to IDLE with no frame_done.
- abort has priority over start in the same cycle.
- mst_cmdack or mst_cmplt arriving outside REQ or XFER is ignored.
- fifo_level may change every cycle; the space check uses the current value only.
- Minimum burst-to-burst gap: 1 cycle in WAIT_SPACE.

Optional Feature:
HDMI_FETCH_AUTORESTART_EN:
- Defined: DONE pulses frame_done, re-latches all config inputs and enters WAIT_SPACE at line 0 without needing start. Only abort or reset returns the block to IDLE. err_sticky is not cleared on auto-restart.
- Undefined: DONE always returns to IDLE.

Test Plan:
- Burst split: base=0xA8000000, stride=5120, hres=40, vres=2, fifo_level=0, master acks and completes after 2 cycles. Required:
  - Line 0 requests (0xA8000000,64), (0xA8000040,64), (0xA8000080,32).
  - Line 1 requests (0xA8001400,64), (0xA8001440,64), (0xA8001480,32).
  - Then exactly one frame_done pulse.
- Back-pressure: fifo_level=245, hres=16. Required: no mst_rd_req issued. Drop fifo_level to 240: request issued 1 cycle later with len=64.
- Handshake hold: delay mst_cmdack by 5 cycles. Required: mst_rd_req, mst_rd_addr and mst_rd_len stay constant for all 5 cycles; mst_rd_req drops 1 cycle after the ack.
- Abort in XFER: pulse abort mid-burst. Required: the block waits for mst_cmplt, then goes IDLE; busy=0 and no frame_done. A following start begins again at frame_base_addr.
- Error and zero size: assert mst_error with the 2nd mst_cmplt. Required: err_sticky=1 and the frame completes. Then start with vres=0: frame_done 2 cycles later, zero requests.
- Reset mid-burst: drop Bus2IP_Resetn while in REQ. Required: mst_rd_req=0 asynchronously and all outputs take their reset values.

Source files
------------

// File: rtl/hdmi_fetch_scheduler.sv
// Frame fetch scheduler: walks a video frame line by line and issues FIFO-space-gated DDR burst reads.
// Optional HDMI_FETCH_AUTORESTART_EN: restart the next frame automatically from DONE.
module hdmi_fetch_scheduler #(
  parameter int FIFO_DEPTH  = 256,
  parameter int BURST_WORDS = 16,
  parameter int LEVEL_W     = 9
) (
  input  logic               Bus2IP_Clk,
  input  logic               Bus2IP_Resetn,
  input  logic               start,
  input  logic               abort,
  input  logic [31:0]        frame_base_addr,
  input  logic [31:0]        line_stride,
  input  logic [10:0]        hres,
  input  logic [9:0]         vres,
  input  logic [LEVEL_W-1:0] fifo_level,
  output logic               mst_rd_req,
  output logic [31:0]        mst_rd_addr,
  output logic [11:0]        mst_rd_len,
  input  logic               mst_cmdack,
  input  logic               mst_cmplt,
  input  logic               mst_error,
  output logic               busy,
  output logic               frame_done,
  output logic [9:0]         line_idx,
  output logic               err_sticky
);

  // state      | meaning
  // IDLE       | waiting for start
  // WAIT_SPACE | waiting until the FIFO can take the whole next burst
  // REQ        | command presented, waiting for mst_cmdack
  // XFER       | burst in flight, waiting for mst_cmplt
  // LINE_END   | line finished, advance to next line or finish frame
  // DONE       | one-cycle frame_done pulse
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_SPACE, S_REQ, S_XFER, S_LINE_END, S_DONE
  } state_t;

  localparam logic [31:0] DEPTH32   = 32'(FIFO_DEPTH);
  localparam logic [10:0] BURST_LEN = 11'(BURST_WORDS);

  state_t      state, state_nxt;
  logic [31:0] line_base;
  logic [31:0] stride_l;
  logic [10:0] hres_l;
  logic [9:0]  vres_l;
  logic [10:0] words_issued;
  logic [10:0] cur_len;
  logic        abort_pend;

  logic [10:0] remaining;
  logic [10:0] this_len;
  logic [31:0] level_ext;
  logic        space_ok;
  logic [31:0] burst_addr;
  logic [10:0] words_after;
  logic        last_line;
  logic        zero_frame;
  logic        load_cfg;

  assign remaining   = hres_l - words_issued;
  assign this_len    = (remaining > BURST_LEN) ? BURST_LEN : remaining;
  assign level_ext   = 32'(fifo_level);
  // A level above FIFO_DEPTH means no space rather than a wrapped huge difference.
  assign space_ok    = (level_ext <= DEPTH32) && ((DEPTH32 - level_ext) >= {21'd0, this_len});
  assign burst_addr  = line_base + {19'd0, words_issued, 2'b00};
  assign words_after = words_issued + cur_len;
  assign last_line   = (line_idx == (vres_l - 10'd1));
  assign zero_frame  = (hres_l == 11'd0) || (vres_l == 10'd0);

`ifdef HDMI_FETCH_AUTORESTART_EN
  assign load_cfg = !abort && ((state == S_IDLE && start) || state == S_DONE);
`else
  assign load_cfg = !abort && (state == S_IDLE && start);
`endif

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) state <= S_IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!abort && start) state_nxt = S_WAIT_SPACE;
      end
      S_WAIT_SPACE: begin
        if (abort)           state_nxt = S_IDLE;
        else if (zero_frame) state_nxt = S_DONE;
        else if (space_ok)   state_nxt = S_REQ;
      end
      S_REQ: begin
        if (mst_cmdack) state_nxt = S_XFER;
      end
      S_XFER: begin
        if (mst_cmplt) begin
          if (abort_pend || abort)      state_nxt = S_IDLE;
          else if (words_after == hres_l) state_nxt = S_LINE_END;
          else                          state_nxt = S_WAIT_SPACE;
        end
      end
      S_LINE_END: begin
        if (abort)          state_nxt = S_IDLE;
        else if (last_line) state_nxt = S_DONE;
        else                state_nxt = S_WAIT_SPACE;
      end
      S_DONE: begin
`ifdef HDMI_FETCH_AUTORESTART_EN
        state_nxt = abort ? S_IDLE : S_WAIT_SPACE;
`else
        state_nxt = S_IDLE;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != S_IDLE);
    frame_done = (state == S_DONE);
    mst_rd_req = (state == S_REQ);
  end

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      line_base    <= 32'd0;
      stride_l     <= 32'd0;
      hres_l       <= 11'd0;
      vres_l       <= 10'd0;
      words_issued <= 11'd0;
      cur_len      <= 11'd0;
      abort_pend   <= 1'b0;
      line_idx     <= 10'd0;
      err_sticky   <= 1'b0;
      mst_rd_addr  <= 32'd0;
      mst_rd_len   <= 12'd0;
    end else begin
      if (state == S_IDLE)
        abort_pend <= 1'b0;
      else if (abort && (state == S_REQ || state == S_XFER))
        abort_pend <= 1'b1;

      if (load_cfg) begin
        line_base    <= frame_base_addr;
        stride_l     <= line_stride;
        hres_l       <= hres;
        vres_l       <= vres;
        words_issued <= 11'd0;
        line_idx     <= 10'd0;
      end
      if (state == S_IDLE && start && !abort)
        err_sticky <= 1'b0;

      if (state == S_WAIT_SPACE && state_nxt == S_REQ) begin
        mst_rd_addr <= burst_addr;
        mst_rd_len  <= 12'({this_len, 2'b00});
        cur_len     <= this_len;
      end

      if (state == S_XFER && mst_cmplt) begin
        words_issued <= words_after;
        if (mst_error) err_sticky <= 1'b1;
      end

      if (state == S_LINE_END) begin
        words_issued <= 11'd0;
        if (state_nxt == S_WAIT_SPACE) begin
          line_idx  <= line_idx + 10'd1;
          line_base <= line_base + stride_l;
        end
      end
    end
  end

endmodule

// File: tb/tb_hdmi_fetch_scheduler.sv
// Scoreboard bench for hdmi_fetch_scheduler: directed frames, a simple master model and a request monitor.
module tb_hdmi_fetch_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [31:0] frame_base_addr, line_stride;
  logic [10:0] hres;
  logic [9:0]  vres;
  logic [8:0]  fifo_level;
  logic        mst_rd_req;
  logic [31:0] mst_rd_addr;
  logic [11:0] mst_rd_len;
  logic        mst_cmdack, mst_cmplt, mst_error;
  logic        busy, frame_done, err_sticky;
  logic [9:0]  line_idx;

  hdmi_fetch_scheduler #(.FIFO_DEPTH(256), .BURST_WORDS(16), .LEVEL_W(9)) dut (
    .Bus2IP_Clk(clk), .Bus2IP_Resetn(rst_n), .start(start), .abort(abort),
    .frame_base_addr(frame_base_addr), .line_stride(line_stride), .hres(hres), .vres(vres),
    .fifo_level(fifo_level), .mst_rd_req(mst_rd_req), .mst_rd_addr(mst_rd_addr),
    .mst_rd_len(mst_rd_len), .mst_cmdack(mst_cmdack), .mst_cmplt(mst_cmplt),
    .mst_error(mst_error), .busy(busy), .frame_done(frame_done), .line_idx(line_idx),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [11:0] len;
    logic [9:0]  line;
  } req_t;

  req_t exp_q[$];
  req_t cur_exp;
  int   errors = 0;
  int   checks = 0;
  int   req_rises = 0;
  int   req_high_cycles = 0;
  int   done_seen = 0;
  int   burst_no = 0;
  int   err_burst = -1;
  int   ack_delay = 0;
  int   cmplt_delay = 2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_req(input logic [31:0] a, input logic [11:0] l, input logic [9:0] ln);
    req_t r;
    r.addr = a; r.len = l; r.line = ln;
    exp_q.push_back(r);
  endtask

  task automatic start_frame(input logic [31:0] base, input logic [31:0] stride,
                             input logic [10:0] h, input logic [9:0] v);
    @(negedge clk);
    frame_base_addr = base; line_stride = stride; hres = h; vres = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_timeout", busy, 0);
  endtask

  // Master model: ack after ack_delay cycles, complete cmplt_delay cycles later.
  initial begin
    mst_cmdack = 1'b0; mst_cmplt = 1'b0; mst_error = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mst_rd_req) begin
        repeat (ack_delay) begin @(posedge clk); #1; end
        mst_cmdack = 1'b1;
        @(posedge clk); #1;
        mst_cmdack = 1'b0;
        repeat (cmplt_delay) begin @(posedge clk); #1; end
        mst_error = (burst_no == err_burst);
        mst_cmplt = 1'b1;
        @(posedge clk); #1;
        mst_cmplt = 1'b0;
        mst_error = 1'b0;
        burst_no++;
      end
    end
  end

  // Monitor: pops the scoreboard on each new request and checks it stays put until accepted.
  initial begin
    logic prev_req, prev_ack;
    prev_req = 1'b0; prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (mst_rd_req && !prev_req) begin
        req_rises++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got addr=0x%0h len=%0d expected none", mst_rd_addr, mst_rd_len);
        end else begin
          cur_exp = exp_q.pop_front();
          check("req_addr", mst_rd_addr, cur_exp.addr);
          check("req_len", mst_rd_len, cur_exp.len);
          check("req_line", line_idx, cur_exp.line);
        end
      end else if (mst_rd_req && prev_req) begin
        check("hold_addr", mst_rd_addr, cur_exp.addr);
        check("hold_len", mst_rd_len, cur_exp.len);
      end
      if (prev_req && prev_ack) check("req_drop", mst_rd_req, 0);
      if (mst_rd_req) req_high_cycles++;
      if (frame_done) done_seen++;
      prev_req = mst_rd_req;
      prev_ack = mst_cmdack;
    end
  end

  initial begin
    int d0, r0, h0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    frame_base_addr = 32'd0; line_stride = 32'd0; hres = 11'd0; vres = 10'd0;
    fifo_level = 9'd0;
    #1;
    check("rst_req", mst_rd_req, 0);
    check("rst_addr", mst_rd_addr, 0);
    check("rst_len", mst_rd_len, 0);
    check("rst_busy", busy, 0);
    check("rst_line", line_idx, 0);
    check("rst_err", err_sticky, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Burst split across two lines
    push_req(32'hA800_0000, 12'd64, 10'd0);
    push_req(32'hA800_0040, 12'd64, 10'd0);
    push_req(32'hA800_0080, 12'd32, 10'd0);
    push_req(32'hA800_1400, 12'd64, 10'd1);
    push_req(32'hA800_1440, 12'd64, 10'd1);
    push_req(32'hA800_1480, 12'd32, 10'd1);
    d0 = done_seen;
    start_frame(32'hA800_0000, 32'd5120, 11'd40, 10'd2);
    check("split_busy", busy, 1);
    wait_idle(300);
    check("split_done", done_seen - d0, 1);
    check("split_sb_empty", exp_q.size(), 0);

    // Back-pressure: 11 free words cannot take a 16-word burst
    fifo_level = 9'd245;
    r0 = req_rises;
    start_frame(32'h0010_0000, 32'd64, 11'd16, 10'd1);
    repeat (10) @(negedge clk);
    check("bp_no_req", req_rises - r0, 0);
    push_req(32'h0010_0000, 12'd64, 10'd0);
    fifo_level = 9'd240;
    @(negedge clk);
    check("bp_req_after_space", mst_rd_req, 1);
    wait_idle(100);
    fifo_level = 9'd0;

    // Handshake hold with late ack
    ack_delay = 5;
    h0 = req_high_cycles;
    push_req(32'h0000_1000, 12'd64, 10'd0);
    start_frame(32'h0000_1000, 32'd0, 11'd16, 10'd1);
    wait_idle(100);
    check("hold_req_cycles", req_high_cycles - h0, 6);
    ack_delay = 0;

    // Abort while a burst is in flight
    d0 = done_seen;
    push_req(32'h0000_2000, 12'd64, 10'd0);
    start_frame(32'h0000_2000, 32'h100, 11'd40, 10'd2);
    for (int i = 0; i < 50 && !mst_rd_req; i++) @(negedge clk);
    for (int i = 0; i < 50 && mst_rd_req; i++) @(negedge clk);
    check("abort_in_xfer_req", mst_rd_req, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_waits_cmplt", busy, 1);
    wait_idle(50);
    check("abort_no_done", done_seen - d0, 0);
    check("abort_sb_empty", exp_q.size(), 0);
    push_req(32'h0000_2000, 12'd64, 10'd0);
    start_frame(32'h0000_2000, 32'h100, 11'd16, 10'd1);
    wait_idle(100);
    check("restart_done", done_seen - d0, 1);

    // Error on the 2nd completion, frame still finishes
    d0 = done_seen;
    err_burst = burst_no + 1;
    push_req(32'h0000_3000, 12'd64, 10'd0);
    push_req(32'h0000_3040, 12'd64, 10'd0);
    push_req(32'h0000_3080, 12'd32, 10'd0);
    start_frame(32'h0000_3000, 32'd0, 11'd40, 10'd1);
    wait_idle(300);
    check("err_sticky_set", err_sticky, 1);
    check("err_frame_done", done_seen - d0, 1);
    err_burst = -1;

    // Zero-size frame: no requests, frame_done two cycles after start
    r0 = req_rises;
    start_frame(32'h0000_4000, 32'd0, 11'd16, 10'd0);
    check("zero_fd_early", frame_done, 0);
    check("err_cleared_by_start", err_sticky, 0);
    @(negedge clk);
    check("zero_fd", frame_done, 1);
    wait_idle(10);
    check("zero_no_req", req_rises - r0, 0);

    // Reset while in REQ
    ack_delay = 5;
    push_req(32'h0000_5000, 12'd64, 10'd0);
    start_frame(32'h0000_5000, 32'd0, 11'd16, 10'd1);
    for (int i = 0; i < 20 && !mst_rd_req; i++) @(negedge clk);
    check("pre_reset_req", mst_rd_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", mst_rd_req, 0);
    check("async_rst_addr", mst_rd_addr, 0);
    check("async_rst_len", mst_rd_len, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", frame_done, 0);
    check("async_rst_line", line_idx, 0);
    check("async_rst_err", err_sticky, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("post_reset_idle", busy, 0);
    check("final_sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
